alu_arbiter: RTL and testbench

Shares the single combinational `alu` datapath between `NUM_REQ` requesters (e.g. the integer pipeline, the address-generation unit, the CSR unit), using round-robin arbitration. Each accepted request is executed in the cycle it is granted, and its result is captured in a one-entry output register tagged with the requester ID. Requesters sit on valid/ready handshakes on both the request side and the response side.

---
 rtl/alu_arbiter.sv | 178 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters.
// Ports: i_clk/i_rst, per-requester valid/ready + packed operands/ops, one-entry tagged response.
//
// alu: combinational integer ALU.
//   i_operation : op code (ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9)
//   i_a, i_b    : operands
//   o_result    : result, 0 for any undefined op code
module alu #(
    parameter int WORD_SIZE  = 32,
    parameter int ALU_OPSIZE = 4
) (
    input  logic [ALU_OPSIZE-1:0] i_operation,
    input  logic [WORD_SIZE-1:0]  i_a,
    input  logic [WORD_SIZE-1:0]  i_b,
    output logic [WORD_SIZE-1:0]  o_result
);
    localparam int SHW = $clog2(WORD_SIZE);

    localparam logic [ALU_OPSIZE-1:0] ALU_ADD  = ALU_OPSIZE'(0);
    localparam logic [ALU_OPSIZE-1:0] ALU_SUB  = ALU_OPSIZE'(1);
    localparam logic [ALU_OPSIZE-1:0] ALU_SLL  = ALU_OPSIZE'(2);
    localparam logic [ALU_OPSIZE-1:0] ALU_SLT  = ALU_OPSIZE'(3);
    localparam logic [ALU_OPSIZE-1:0] ALU_SLTU = ALU_OPSIZE'(4);
    localparam logic [ALU_OPSIZE-1:0] ALU_XOR  = ALU_OPSIZE'(5);
    localparam logic [ALU_OPSIZE-1:0] ALU_SRL  = ALU_OPSIZE'(6);
    localparam logic [ALU_OPSIZE-1:0] ALU_SRA  = ALU_OPSIZE'(7);
    localparam logic [ALU_OPSIZE-1:0] ALU_OR   = ALU_OPSIZE'(8);
    localparam logic [ALU_OPSIZE-1:0] ALU_AND  = ALU_OPSIZE'(9);

    logic [SHW-1:0] shamt;

    assign shamt = i_b[SHW-1:0];

    always_comb begin
        o_result = '0;
        case (i_operation)
            ALU_ADD:  o_result = i_a + i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_SLL:  o_result = i_a << shamt;
            ALU_SLT:  o_result = {{(WORD_SIZE-1){1'b0}},
                                  ($signed(i_a) < $signed(i_b))};
            ALU_SLTU: o_result = {{(WORD_SIZE-1){1'b0}}, (i_a < i_b)};
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_SRL:  o_result = i_a >> shamt;
            ALU_SRA:  o_result = $unsigned($signed(i_a) >>> shamt);
            ALU_OR:   o_result = i_a | i_b;
            ALU_AND:  o_result = i_a & i_b;
            default:  o_result = '0;
        endcase
    end
endmodule

// alu_arbiter: top level.
//   i_req_valid/o_req_ready     : per-requester handshake, ready is one-hot or zero
//   i_req_operand_A/B, _operation : packed per-requester slices, slice k = requester k
//   o_rsp_valid/i_rsp_ready     : response handshake on the one-entry result register
//   o_rsp_id, o_rsp_result      : requester tag and ALU result of the held response
module alu_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int WORD_SIZE  = 32,
    parameter int ALU_OPSIZE = 4,
    parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic [NUM_REQ*WORD_SIZE-1:0]  i_req_operand_A,
    input  logic [NUM_REQ*WORD_SIZE-1:0]  i_req_operand_B,
    input  logic [NUM_REQ*ALU_OPSIZE-1:0] i_req_operation,
    output logic                          o_rsp_valid,
    input  logic                          i_rsp_ready,
    output logic [ID_W-1:0]               o_rsp_id,
    output logic [WORD_SIZE-1:0]          o_rsp_result
);
    logic                  full_q, full_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic [WORD_SIZE-1:0]  rsp_result_q, rsp_result_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;

    logic                  can_accept;
    logic                  gnt_any;
    logic [ID_W-1:0]       gnt_id;
    logic [ID_W-1:0]       cand;

    logic [WORD_SIZE-1:0]  alu_a;
    logic [WORD_SIZE-1:0]  alu_b;
    logic [ALU_OPSIZE-1:0] alu_op;
    logic [WORD_SIZE-1:0]  alu_result;

    // The slot frees up either because it is empty or because the consumer
    // drains it this very cycle, which gives pass-through with no bubble.
    assign can_accept = !full_q || i_rsp_ready;

    // Search upward from rr_ptr, wrapping at NUM_REQ (need not be a power of 2).
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(rr_ptr_q) + i >= NUM_REQ) begin
                cand = ID_W'(int'(rr_ptr_q) + i - NUM_REQ);
            end else begin
                cand = ID_W'(int'(rr_ptr_q) + i);
            end
            if (!gnt_any && i_req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_id  = cand;
            end
        end
        // A grant during reset would be lost, so none is offered.
        if (!can_accept || i_rst) begin
            gnt_any = 1'b0;
        end
    end

    assign o_req_ready = gnt_any ? (NUM_REQ'(1) << gnt_id) : '0;

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_id == ID_W'(k)) begin
                alu_a  = i_req_operand_A[k*WORD_SIZE +: WORD_SIZE];
                alu_b  = i_req_operand_B[k*WORD_SIZE +: WORD_SIZE];
                alu_op = i_req_operation[k*ALU_OPSIZE +: ALU_OPSIZE];
            end
        end
    end

    alu #(
        .WORD_SIZE  (WORD_SIZE),
        .ALU_OPSIZE (ALU_OPSIZE)
    ) u_alu (
        .i_operation (alu_op),
        .i_a         (alu_a),
        .i_b         (alu_b),
        .o_result    (alu_result)
    );

    always_comb begin
        full_d       = full_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rr_ptr_d     = rr_ptr_q;
        if (gnt_any) begin
            full_d       = 1'b1;
            rsp_id_d     = gnt_id;
            rsp_result_d = alu_result;
            if (gnt_id == ID_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_id + ID_W'(1);
            end
        end else if (i_rsp_ready) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            full_q       <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rr_ptr_q     <= '0;
        end else begin
            full_q       <= full_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign o_rsp_valid  = full_q;
    assign o_rsp_id     = rsp_id_q;
    assign o_rsp_result = rsp_result_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed vector table on a 2-requester instance,
// plus a hand-written wrap/skip sequence on a 4-requester instance.
module tb_alu_arbiter;
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_BAD  = 4'd15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // 2-requester instance
    logic        rst2;
    logic [1:0]  valid2;
    logic [1:0]  ready2;
    logic [63:0] opa2;
    logic [63:0] opb2;
    logic [7:0]  op2;
    logic        rsp_valid2;
    logic        rsp_ready2;
    logic        rsp_id2;
    logic [31:0] rsp_res2;

    alu_arbiter #(.NUM_REQ(2)) u2 (
        .i_clk           (clk),
        .i_rst           (rst2),
        .i_req_valid     (valid2),
        .o_req_ready     (ready2),
        .i_req_operand_A (opa2),
        .i_req_operand_B (opb2),
        .i_req_operation (op2),
        .o_rsp_valid     (rsp_valid2),
        .i_rsp_ready     (rsp_ready2),
        .o_rsp_id        (rsp_id2),
        .o_rsp_result    (rsp_res2)
    );

    // 4-requester instance
    logic         rst4;
    logic [3:0]   valid4;
    logic [3:0]   ready4;
    logic [127:0] opa4;
    logic [127:0] opb4;
    logic [15:0]  op4;
    logic         rsp_valid4;
    logic         rsp_ready4;
    logic [1:0]   rsp_id4;
    logic [31:0]  rsp_res4;

    alu_arbiter #(.NUM_REQ(4)) u4 (
        .i_clk           (clk),
        .i_rst           (rst4),
        .i_req_valid     (valid4),
        .o_req_ready     (ready4),
        .i_req_operand_A (opa4),
        .i_req_operand_B (opb4),
        .i_req_operation (op4),
        .o_rsp_valid     (rsp_valid4),
        .i_rsp_ready     (rsp_ready4),
        .o_rsp_id        (rsp_id4),
        .o_rsp_result    (rsp_res4)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  valid;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [3:0]  op0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [3:0]  op1;
        logic        rsp_rdy;
        logic [1:0]  e_rdy;
        logic        e_vld;
        logic        chk;
        logic        e_id;
        logic [31:0] e_res;
        logic        e_rr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h, expected %h",
                     nm, row, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [1:0] valid,
                       input logic [31:0] a0, input logic [31:0] b0,
                       input logic [3:0] op0,
                       input logic [31:0] a1, input logic [31:0] b1,
                       input logic [3:0] op1,
                       input logic rsp_rdy, input logic [1:0] e_rdy,
                       input logic e_vld, input logic chkd,
                       input logic e_id, input logic [31:0] e_res,
                       input logic e_rr);
        vec_t v;
        v.rst = rst; v.valid = valid;
        v.a0 = a0; v.b0 = b0; v.op0 = op0;
        v.a1 = a1; v.b1 = b1; v.op1 = op1;
        v.rsp_rdy = rsp_rdy; v.e_rdy = e_rdy;
        v.e_vld = e_vld; v.chk = chkd;
        v.e_id = e_id; v.e_res = e_res; v.e_rr = e_rr;
        tbl.push_back(v);
    endtask

    // One granted cycle on the 4-requester instance; a response always follows.
    task automatic step4(input int row, input logic [3:0] v,
                         input logic [3:0] e_rdy, input logic [1:0] e_id,
                         input logic [31:0] e_res, input logic [1:0] e_rr);
        valid4 = v;
        @(negedge clk);
        chk("rdy4", row, 32'(ready4), 32'(e_rdy));
        @(posedge clk);
        #1;
        chk("vld4", row, 32'(rsp_valid4), 32'd1);
        chk("id4", row, 32'(rsp_id4), 32'(e_id));
        chk("res4", row, rsp_res4, e_res);
        chk("rr4", row, 32'(u4.rr_ptr_q), 32'(e_rr));
    endtask

    initial begin
        rst2 = 1'b1; valid2 = '0; opa2 = '0; opb2 = '0; op2 = '0;
        rsp_ready2 = 1'b1;
        rst4 = 1'b1; valid4 = '0; opa4 = '0; opb4 = '0; op4 = '0;
        rsp_ready4 = 1'b1;

        // reset state, reset gates ready
        add(1'b1, 2'b01, 32'd5, 32'd7, OP_ADD, 32'd0, 32'd0, OP_ADD,
            1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        // single request
        add(1'b0, 2'b01, 32'd5, 32'd7, OP_ADD, 32'd0, 32'd0, OP_ADD,
            1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 32'd12, 1'b1);
        add(1'b0, 2'b00, 32'd5, 32'd7, OP_ADD, 32'd0, 32'd0, OP_ADD,
            1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        // reset with both valid: nothing granted
        add(1'b1, 2'b11, 32'd10, 32'd3, OP_SUB, 32'hF0, 32'h0F, OP_XOR,
            1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        // round robin, back-to-back
        add(1'b0, 2'b11, 32'd10, 32'd3, OP_SUB, 32'hF0, 32'h0F, OP_XOR,
            1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 32'd7, 1'b1);
        add(1'b0, 2'b11, 32'd10, 32'd3, OP_SUB, 32'hF0, 32'h0F, OP_XOR,
            1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 32'hFF, 1'b0);
        add(1'b0, 2'b11, 32'd10, 32'd3, OP_SUB, 32'hF0, 32'h0F, OP_XOR,
            1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 32'd7, 1'b1);
        add(1'b0, 2'b11, 32'd10, 32'd3, OP_SUB, 32'hF0, 32'h0F, OP_XOR,
            1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 32'hFF, 1'b0);
        // backpressure: hold three cycles
        for (int i = 0; i < 3; i++) begin
            add(1'b0, 2'b11, 32'd10, 32'd3, OP_SUB, 32'hF0, 32'h0F, OP_XOR,
                1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 32'hFF, 1'b0);
        end
        // drain and grant in the same cycle
        add(1'b0, 2'b11, 32'd10, 32'd3, OP_SUB, 32'hF0, 32'h0F, OP_XOR,
            1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 32'd7, 1'b1);
        add(1'b0, 2'b00, 32'd10, 32'd3, OP_SUB, 32'hF0, 32'h0F, OP_XOR,
            1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        // reset while full and requester 1 valid
        add(1'b0, 2'b10, 32'd10, 32'd3, OP_SUB, 32'hF0, 32'h0F, OP_XOR,
            1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 32'hFF, 1'b0);
        add(1'b1, 2'b10, 32'd10, 32'd3, OP_SUB, 32'hF0, 32'h0F, OP_XOR,
            1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
        add(1'b0, 2'b10, 32'd10, 32'd3, OP_SUB, 32'hF0, 32'h0F, OP_XOR,
            1'b0, 2'b10, 1'b1, 1'b1, 1'b1, 32'hFF, 1'b0);
        // op coverage
        add(1'b0, 2'b01, 32'd1, 32'd2, OP_SLTU, 32'd0, 32'd0, OP_ADD,
            1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 32'd1, 1'b1);
        add(1'b0, 2'b10, 32'd0, 32'd0, OP_ADD, 32'd1, 32'd4, OP_SLL,
            1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 32'd16, 1'b0);
        add(1'b0, 2'b01, 32'h80, 32'd3, OP_SRL, 32'd0, 32'd0, OP_ADD,
            1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 32'h10, 1'b1);
        add(1'b0, 2'b10, 32'd0, 32'd0, OP_ADD, 32'd5, 32'd6, OP_BAD,
            1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 32'd0, 1'b0);
        add(1'b0, 2'b01, 32'hFFFF_FFFF, 32'd1, OP_SLT, 32'd0, 32'd0, OP_ADD,
            1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 32'd1, 1'b1);
        // hold then drain
        add(1'b0, 2'b00, 32'd0, 32'd0, OP_ADD, 32'd0, 32'd0, OP_ADD,
            1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 32'd1, 1'b1);
        add(1'b0, 2'b00, 32'd0, 32'd0, OP_ADD, 32'd0, 32'd0, OP_ADD,
            1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

        @(posedge clk);
        #1;
        foreach (tbl[i]) begin
            rst2       = tbl[i].rst;
            valid2     = tbl[i].valid;
            opa2       = {tbl[i].a1, tbl[i].a0};
            opb2       = {tbl[i].b1, tbl[i].b0};
            op2        = {tbl[i].op1, tbl[i].op0};
            rsp_ready2 = tbl[i].rsp_rdy;
            @(negedge clk);
            chk("rdy", i, 32'(ready2), 32'(tbl[i].e_rdy));
            @(posedge clk);
            #1;
            chk("vld", i, 32'(rsp_valid2), 32'(tbl[i].e_vld));
            if (tbl[i].chk) begin
                chk("id", i, 32'(rsp_id2), 32'(tbl[i].e_id));
                chk("res", i, rsp_res2, tbl[i].e_res);
            end
            chk("rr", i, 32'(u2.rr_ptr_q), 32'(tbl[i].e_rr));
        end

        // wrap and skip on four requesters
        rst4 = 1'b0;
        opa4 = {32'd0, 32'hF0, 32'd0, 32'd1};
        opb4 = {32'd0, 32'h0F, 32'd0, 32'd1};
        op4  = {OP_ADD, OP_OR, OP_ADD, OP_ADD};
        step4(100, 4'b0100, 4'b0100, 2'd2, 32'hFF, 2'd3);
        step4(101, 4'b0101, 4'b0001, 2'd0, 32'd2, 2'd1);
        step4(102, 4'b0101, 4'b0100, 2'd2, 32'hFF, 2'd3);
        step4(103, 4'b0101, 4'b0001, 2'd0, 32'd2, 2'd1);
        valid4 = '0;
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
